// File: rtl/serial_div_master.sv
// rtl/serial_div_master.sv - Wishbone initiator driving a memory-mapped divider for one command at a time.
module serial_div_master #(
    parameter int WBW         = 32,
    parameter int XLEN        = 32,
    parameter int WAIT_CYCLES = 34,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [XLEN-1:0]   cmd_dividend_i,
    input  logic [XLEN-1:0]   cmd_divisor_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_quotient_o,
    output logic [XLEN-1:0]   rsp_remainder_o,
    output logic              rsp_err_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [WBW/8-1:0]  wbm_sel_o,
    output logic [WBW-1:0]    wbm_adr_o,
    output logic [WBW-1:0]    wbm_dat_o,
    input  logic              wbm_ack_i,
    input  logic [WBW-1:0]    wbm_dat_i,
    output logic              busy_o
);

    localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, WR_DVD, WR_DVS, WR_START, WAIT, RD_QUO, RD_REM, RESP
    } state_t;

    state_t            state;
    state_t            launch_state;
    logic              launch;
    logic              ack;
    logic [XLEN-1:0]   dvs_q;
    logic [WW-1:0]     wait_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic [WBW-1:0]    launch_adr;
    logic [WBW-1:0]    launch_dat;
    logic              launch_we;

    // An ack only counts while our strobe is out; stray acks are dropped here.
    assign ack = wbm_ack_i & wbm_stb_o;

    function automatic logic [WBW-1:0] req_adr(input state_t s);
        case (s)
            WR_DVD:   req_adr = WBW'(32'h8000_0000);
            WR_DVS:   req_adr = WBW'(32'h4000_0000);
            WR_START: req_adr = WBW'(32'h0200_0000);
            RD_QUO:   req_adr = WBW'(32'h2000_0000);
            RD_REM:   req_adr = WBW'(32'h1000_0000);
            default:  req_adr = '0;
        endcase
    endfunction

    // A new strobe is launched on the same edge that enters the state, or after the gap cycle.
    always_comb begin
        launch       = 1'b0;
        launch_state = state;
        case (state)
            IDLE: begin
                launch       = cmd_valid_i & cmd_ready_o;
                launch_state = WR_DVD;
            end
            WAIT: begin
                launch       = (wait_cnt == WW'(WAIT_CYCLES - 1));
                launch_state = RD_QUO;
            end
            WR_DVD, WR_DVS, WR_START, RD_QUO, RD_REM: launch = ~wbm_stb_o;
            default: launch = 1'b0;
        endcase
    end

    always_comb begin
        launch_adr = req_adr(launch_state);
        launch_we  = (launch_state == WR_DVD) || (launch_state == WR_DVS) ||
                     (launch_state == WR_START);
        case (launch_state)
            WR_DVD:  launch_dat = WBW'(cmd_dividend_i);
            WR_DVS:  launch_dat = WBW'(dvs_q);
            default: launch_dat = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state           <= IDLE;
            cmd_ready_o     <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_quotient_o  <= '0;
            rsp_remainder_o <= '0;
            rsp_err_o       <= 1'b0;
            wbm_cyc_o       <= 1'b0;
            wbm_stb_o       <= 1'b0;
            wbm_we_o        <= 1'b0;
            wbm_sel_o       <= '0;
            wbm_adr_o       <= '0;
            wbm_dat_o       <= '0;
            busy_o          <= 1'b0;
            dvs_q           <= '0;
            wait_cnt        <= '0;
            tmo_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        state           <= WR_DVD;
                        cmd_ready_o     <= 1'b0;
                        busy_o          <= 1'b1;
                        dvs_q           <= cmd_divisor_i;
                        rsp_quotient_o  <= '0;
                        rsp_remainder_o <= '0;
                        rsp_err_o       <= 1'b0;
                    end
                end
                WR_DVD, WR_DVS, WR_START, RD_QUO, RD_REM: begin
                    if (wbm_stb_o) begin
                        if (ack) begin
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            wbm_we_o  <= 1'b0;
                            wbm_sel_o <= '0;
                            wbm_adr_o <= '0;
                            wbm_dat_o <= '0;
                            tmo_cnt   <= '0;
                            case (state)
                                WR_DVD:   state <= WR_DVS;
                                WR_DVS:   state <= WR_START;
                                WR_START: begin
                                    state    <= WAIT;
                                    wait_cnt <= '0;
                                end
                                RD_QUO: begin
                                    state          <= RD_REM;
                                    rsp_quotient_o <= XLEN'(wbm_dat_i);
                                end
                                default: begin
                                    state           <= RESP;
                                    rsp_remainder_o <= XLEN'(wbm_dat_i);
                                    rsp_valid_o     <= 1'b1;
                                end
                            endcase
                        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                            // Responder gave up on us: abandon the bus and report an error.
                            wbm_cyc_o       <= 1'b0;
                            wbm_stb_o       <= 1'b0;
                            wbm_we_o        <= 1'b0;
                            wbm_sel_o       <= '0;
                            wbm_adr_o       <= '0;
                            wbm_dat_o       <= '0;
                            tmo_cnt         <= '0;
                            state           <= RESP;
                            rsp_valid_o     <= 1'b1;
                            rsp_err_o       <= 1'b1;
                            rsp_quotient_o  <= '0;
                            rsp_remainder_o <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == WW'(WAIT_CYCLES - 1)) begin
                        state <= RD_QUO;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (launch) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= launch_we;
                wbm_sel_o <= '1;
                wbm_adr_o <= launch_adr;
                wbm_dat_o <= launch_dat;
            end
        end
    end

endmodule

// File: tb/tb_serial_div_master.sv
// tb/tb_serial_div_master.sv - Scoreboard bench for serial_div_master with a divider-peripheral responder.
module tb_serial_div_master;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_dividend, cmd_divisor;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_quotient, rsp_remainder;
    logic        rsp_err;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack;
    logic        busy;

    always #5 clk = ~clk;

    serial_div_master dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_dividend_i(cmd_dividend), .cmd_divisor_i(cmd_divisor),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_quotient_o(rsp_quotient), .rsp_remainder_o(rsp_remainder), .rsp_err_o(rsp_err),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
        .wbm_sel_o(wbm_sel), .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack), .wbm_dat_i(wbm_dat_i), .busy_o(busy)
    );

    typedef struct { logic [31:0] q; logic [31:0] r; logic e; } rsp_t;
    typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; } bus_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc_cnt = 0;
    int   last_acc = 0;
    int   hs_edge = 0;
    rsp_t sb[$];
    bus_t bus_log[$];
    int   runs[$];
    int   bad_fields = 0;

    // Responder: a memory-mapped divider with programmable ack latency.
    logic        ack_r = 1'b0, spur = 1'b0, noack = 1'b0;
    logic [31:0] rd_dat = '0, spur_dat = '0;
    logic [31:0] r_dvd = '0, r_dvs = '0, r_q = '0, r_r = '0;
    int          lat = 1, lat_cnt = 0, run = 0;

    assign wbm_ack   = ack_r | spur;
    assign wbm_dat_i = spur ? spur_dat : rd_dat;

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (!reset_ni) begin
            ack_r = 1'b0; lat_cnt = 0; run = 0;
        end else begin
            if (wbm_stb) run++;
            else if (run != 0) begin runs.push_back(run); run = 0; end
            if (ack_r) begin
                ack_r = 1'b0; lat_cnt = 0;
            end else if (wbm_stb && !noack) begin
                lat_cnt++;
                if (lat_cnt > lat) begin
                    ack_r = 1'b1;
                    bus_log.push_back('{wbm_we, wbm_adr, wbm_dat_o});
                    if (wbm_sel != 4'hF || (!wbm_we && wbm_dat_o != 0) || !wbm_cyc) bad_fields++;
                    if (wbm_we) begin
                        if (wbm_adr == 32'h8000_0000) r_dvd = wbm_dat_o;
                        if (wbm_adr == 32'h4000_0000) r_dvs = wbm_dat_o;
                        if (wbm_adr == 32'h0200_0000) begin
                            r_q = (r_dvs != 0) ? r_dvd / r_dvs : 32'hFFFF_FFFF;
                            r_r = (r_dvs != 0) ? r_dvd % r_dvs : r_dvd;
                        end
                    end else begin
                        rd_dat = (wbm_adr == 32'h2000_0000) ? r_q : r_r;
                    end
                end
            end
        end
    end

    // Callers are always at a negedge when invoking these tasks.
    task automatic accept_cmd(input logic [31:0] a, input logic [31:0] b, input bit err, input bit push);
        int n = 0;
        cmd_valid = 1'b1; cmd_dividend = a; cmd_divisor = b;
        while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            tests++; fails++;
            $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
        @(posedge clk); #1; last_acc = cyc_cnt;
        @(negedge clk); cmd_valid = 1'b0;
        if (push) begin
            if (err) sb.push_back('{32'd0, 32'd0, 1'b1});
            else     sb.push_back('{a / b, a % b, 1'b0});
        end
    endtask

    task automatic collect(input int hold, output rsp_t got, output int rel, output bit stable, output bit to);
        int n = 0;
        to = 1'b0; stable = 1'b1; rel = -1;
        got = '{32'd0, 32'd0, 1'b0};
        while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
        if (!rsp_valid) begin to = 1'b1; return; end
        rel = cyc_cnt - last_acc + 1;
        got = '{rsp_quotient, rsp_remainder, rsp_err};
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || rsp_quotient != got.q || rsp_remainder != got.r ||
                rsp_err != got.e || cmd_ready) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1; hs_edge = cyc_cnt;
        @(negedge clk); rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_dividend = '0; cmd_divisor = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({cmd_ready, rsp_valid, busy, wbm_cyc, wbm_stb, wbm_we, rsp_err} !== 7'b0 ||
            wbm_adr !== 32'h0 || rsp_quotient !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b busy=%0b cyc=%0b stb=%0b adr=%h, required all 0",
                     cmd_ready, rsp_valid, busy, wbm_cyc, wbm_stb, wbm_adr);
        end
        reset_ni = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: cmd_ready=%0b busy=%0b, required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        rsp_t got, exp; int rel; bit st, to;
        logic        e_we[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] e_adr[5] = '{32'h8000_0000, 32'h4000_0000, 32'h0200_0000, 32'h2000_0000, 32'h1000_0000};
        logic [31:0] e_dat[5] = '{32'd100, 32'd7, 32'd0, 32'd0, 32'd0};
        bus_log.delete(); runs.delete(); bad_fields = 0;
        accept_cmd(100, 7, 1'b0, 1'b1);
        collect(0, got, rel, st, to);
        exp = sb.pop_front();
        tests++;
        if (to || rel != 48) begin
            fails++; $display("FAIL basic_latency: rsp_valid cycle %0d (timeout=%0b), required 48", rel, to);
        end
        tests++;
        if (got.q !== exp.q || got.r !== exp.r || got.e !== exp.e || exp.q !== 32'd14 || exp.r !== 32'd2) begin
            fails++; $display("FAIL basic_payload: q=%0d r=%0d e=%0b, required 14/2/0", got.q, got.r, got.e);
        end
        tests++;
        if (bus_log.size() != 5) begin
            fails++; $display("FAIL basic_bus_count: %0d transactions, required 5", bus_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (bus_log[i].we !== e_we[i] || bus_log[i].adr !== e_adr[i] || bus_log[i].dat !== e_dat[i]) begin
                    fails++;
                    $display("FAIL basic_bus_%0d: we=%0b adr=%h dat=%0d, required we=%0b adr=%h dat=%0d",
                             i, bus_log[i].we, bus_log[i].adr, bus_log[i].dat, e_we[i], e_adr[i], e_dat[i]);
                end
            end
        end
        tests++;
        if (bad_fields != 0) begin
            fails++; $display("FAIL basic_fields: %0d bad sel/dat/cyc cycles, required 0", bad_fields);
        end
        tests++;
        if (runs.size() != 5 || runs.sum() != 10) begin
            fails++; $display("FAIL basic_strobe_runs: %0d runs totalling %0d, required 5 runs of 2", runs.size(), runs.sum());
        end
    endtask

    task automatic test_hold();
        rsp_t got, exp; int rel; bit st, to;
        accept_cmd(20, 6, 1'b0, 1'b1);
        cmd_valid = 1'b1; cmd_dividend = 45; cmd_divisor = 4;
        collect(10, got, rel, st, to);
        exp = sb.pop_front();
        tests++;
        if (to || !st) begin
            fails++; $display("FAIL hold_stable: stable=%0b timeout=%0b, required 1/0", st, to);
        end
        tests++;
        if (got.q !== exp.q || got.r !== exp.r || got.e !== exp.e) begin
            fails++; $display("FAIL hold_payload: q=%0d r=%0d e=%0b, required %0d/%0d/%0b", got.q, got.r, got.e, exp.q, exp.r, exp.e);
        end
        accept_cmd(45, 4, 1'b0, 1'b1);
        tests++;
        if (last_acc - hs_edge != 1) begin
            fails++; $display("FAIL hold_accept_edge: accepted %0d edges after handshake, required 1", last_acc - hs_edge);
        end
        collect(0, got, rel, st, to);
        exp = sb.pop_front();
        tests++;
        if (to || rel != 48 || got.q !== exp.q || got.r !== exp.r || got.e !== exp.e) begin
            fails++; $display("FAIL hold_second: cycle %0d q=%0d r=%0d e=%0b, required 48 %0d/%0d/%0b", rel, got.q, got.r, got.e, exp.q, exp.r, exp.e);
        end
    endtask

    task automatic test_timeout();
        rsp_t got, exp; int rel; bit st, to;
        noack = 1'b1; runs.delete();
        accept_cmd(5, 1, 1'b1, 1'b1);
        collect(0, got, rel, st, to);
        exp = sb.pop_front();
        noack = 1'b0;
        tests++;
        if (runs.size() != 1 || runs[0] != 16) begin
            fails++; $display("FAIL timeout_strobe: %0d runs, first %0d, required 1 run of 16", runs.size(), (runs.size() > 0) ? runs[0] : -1);
        end
        tests++;
        if (to || rel != 17) begin
            fails++; $display("FAIL timeout_latency: rsp_valid cycle %0d, required 17", rel);
        end
        tests++;
        if (got.q !== exp.q || got.r !== exp.r || got.e !== exp.e) begin
            fails++; $display("FAIL timeout_payload: q=%0d r=%0d e=%0b, required 0/0/1", got.q, got.r, got.e);
        end
    endtask

    task automatic test_reset_mid();
        rsp_t got, exp; int rel; bit st, to;
        accept_cmd(50, 5, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL rstmid_busy_before: busy=%0b, required 1", busy);
        end
        #2 reset_ni = 1'b0;
        #1;
        tests++;
        if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            fails++; $display("FAIL rstmid_clear: cyc=%0b stb=%0b busy=%0b ready=%0b, required 0", wbm_cyc, wbm_stb, busy, cmd_ready);
        end
        @(negedge clk); reset_ni = 1'b1;
        @(negedge clk);
        accept_cmd(9, 3, 1'b0, 1'b1);
        collect(0, got, rel, st, to);
        exp = sb.pop_front();
        tests++;
        if (to || rel != 48 || got.q !== exp.q || got.r !== exp.r || got.e !== exp.e || exp.q !== 32'd3) begin
            fails++; $display("FAIL rstmid_next: cycle %0d q=%0d r=%0d e=%0b, required 48 3/0/0", rel, got.q, got.r, got.e);
        end
    endtask

    task automatic test_slow();
        rsp_t got, exp; int rel; bit st, to;
        lat = 3; runs.delete();
        accept_cmd(1000, 33, 1'b0, 1'b1);
        collect(0, got, rel, st, to);
        exp = sb.pop_front();
        lat = 1;
        tests++;
        if (to || rel != 58) begin
            fails++; $display("FAIL slow_latency: rsp_valid cycle %0d, required 58", rel);
        end
        tests++;
        if (runs.size() != 5 || runs.sum() != 20) begin
            fails++; $display("FAIL slow_strobe_runs: %0d runs totalling %0d, required 5 runs of 4", runs.size(), runs.sum());
        end
        tests++;
        if (got.q !== exp.q || got.r !== exp.r || got.e !== exp.e) begin
            fails++; $display("FAIL slow_payload: q=%0d r=%0d e=%0b, required %0d/%0d/%0b", got.q, got.r, got.e, exp.q, exp.r, exp.e);
        end
    endtask

    task automatic test_spurious();
        rsp_t got, exp; int rel; bit st, to;
        int   at[3] = '{2, 16, 24};
        bus_log.delete();
        accept_cmd(77, 8, 1'b0, 1'b1);
        spur_dat = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            repeat (at[i]) @(negedge clk);
            spur = 1'b1;
            @(negedge clk);
            spur = 1'b0;
        end
        collect(0, got, rel, st, to);
        exp = sb.pop_front();
        tests++;
        if (to || rel != 48) begin
            fails++; $display("FAIL spurious_latency: rsp_valid cycle %0d, required 48", rel);
        end
        tests++;
        if (got.q !== exp.q || got.r !== exp.r || got.e !== exp.e || bus_log.size() != 5) begin
            fails++; $display("FAIL spurious_payload: q=%h r=%h e=%0b txns=%0d, required %0d/%0d/%0b 5",
                              got.q, got.r, got.e, bus_log.size(), exp.q, exp.r, exp.e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_slow();
        test_spurious();
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/serial_div_master.md
SERIAL_DIV_MASTER -- requirements
Module: serial_div_master

Interface
REQ-001 Parameter WBW, default 32, Wishbone data/address width.
REQ-002 Parameter XLEN, default 32, operand and result width; XLEN SHALL equal WBW.
REQ-003 Parameter WAIT_CYCLES, default 34, cycles between start-write ack and quotient read; legal values are 1 and above.
REQ-004 Parameter TIMEOUT, default 16, maximum cycles a strobe may remain unacknowledged; legal values are 2 and above.
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 reset_ni  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid_i  in  1  / cmd_ready_o  out  1  command handshake.
REQ-008 cmd_dividend_i  in  XLEN  / cmd_divisor_i  in  XLEN  operands, sampled on command accept.
REQ-009 rsp_valid_o  out  1  / rsp_ready_i  in  1  response handshake.
REQ-010 rsp_quotient_o  out  XLEN  / rsp_remainder_o  out  XLEN  / rsp_err_o  out  1  response payload.
REQ-011 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone initiator controls.
REQ-012 wbm_sel_o  out  WBW/8  / wbm_adr_o  out  WBW  / wbm_dat_o  out  WBW  Wishbone request fields.
REQ-013 wbm_ack_i  in  1  / wbm_dat_i  in  WBW  Wishbone response.
REQ-014 busy_o  out  1  high in every state except IDLE.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have states IDLE, WR_DVD, WR_DVS, WR_START, WAIT, RD_QUO, RD_REM, RESP.
REQ-017 IDLE: cmd_ready_o=1; on cmd_valid_i&cmd_ready_o, the block SHALL latch the operands and go to WR_DVD.
REQ-018 Bus states SHALL drive the following cycles:
- WR_DVD: write dividend to adr 0x8000_0000.
- WR_DVS: write divisor to 0x4000_0000.
- WR_START: write 0 to 0x0200_0000.
- RD_QUO: read 0x2000_0000.
- RD_REM: read 0x1000_0000.
REQ-019 During any bus cycle, wbm_sel_o SHALL be all ones; wbm_dat_o SHALL be 0 on reads; wbm_we_o SHALL be 1 for writes and 0 for reads.
REQ-020 wbm_cyc_o and wbm_stb_o SHALL rise the cycle after entering a bus state and stay high until wbm_ack_i is sampled high.
REQ-021 After each ack, cyc/stb SHALL be low for exactly one gap cycle before the next transaction.
REQ-022 Each transaction SHALL therefore take 3 cycles with a zero-wait responder.
REQ-023 wbm_ack_i SHALL be ignored while wbm_stb_o is low.
REQ-024 wbm_dat_i SHALL be captured on the ack of RD_QUO and RD_REM only.
REQ-025 WAIT SHALL be entered on the WR_START ack and last exactly WAIT_CYCLES cycles, the gap cycle included; it then goes to RD_QUO.
REQ-026 RD_REM ack SHALL go to RESP; in RESP, rsp_valid_o=1 with payload stable until rsp_ready_i is sampled high, then the FSM returns to IDLE.
REQ-027 Latency: command accepted at edge ending cycle 0 -> rsp_valid_o high in cycle 14+WAIT_CYCLES with a zero-wait responder.
REQ-028 cmd_ready_o SHALL be 0 in RESP; a command presented during the response handshake SHALL be accepted no earlier than the first IDLE cycle.
REQ-029 A per-transaction counter SHALL count strobe-high cycles without ack.
REQ-030 On reaching TIMEOUT, cyc/stb SHALL drop the next cycle and the FSM SHALL go to RESP with rsp_err_o=1 and quotient/remainder 0.
REQ-031 rsp_err_o SHALL be 0 for normal completion.
REQ-032 Divisor zero SHALL NOT be checked; it is forwarded unchanged.

Reset
REQ-033 On reset_ni low, all state SHALL clear immediately, including mid-transaction, to IDLE.
REQ-034 Reset values: cmd_ready_o=0 while asserted and 1 after release; all other outputs 0; FSM in IDLE; counters 0.

Verification
REQ-035 Bench scenarios (WAIT_CYCLES=34, single-cycle-ack responder model):
- cmd 100/7 -> writes 0x8000_0000=100, 0x4000_0000=7, 0x0200_0000=0; reads return 14/2 -> rsp_valid in cycle 48, quotient=14, remainder=2, err=0.
- rsp_ready_i held low for 10 cycles -> payload and rsp_valid_o stable; cmd_valid_i high throughout, accepted only after IDLE re-entry.
- Responder never acks dividend write, TIMEOUT=16 -> stb low after 16 cycles, err=1, quotient=remainder=0.
- reset_ni pulsed low during WAIT -> cyc/stb/busy_o 0 immediately; next cmd 9/3 completes with quotient=3, remainder=0.
- Responder with 3-cycle ack latency -> stb held, one gap per transaction, results correct, err=0.
- Spurious wbm_ack_i during gap or WAIT -> no state change, no data capture.
